// File: rtl/mem_arb.sv
// Memory bus arbiter: shares one burst bus between instruction line fills and
// data line fills/writebacks, with alternating priority under contention.
module mem_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [DATA_W-1:0]             i_rdata,
    output logic                          i_vld,
    output logic                          i_done,

    input  logic                          d_rd,
    input  logic                          d_wr,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic [$clog2(LINE_BEATS)-1:0] d_beat,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          d_vld,
    output logic                          d_done,

    output logic                          m_req,
    output logic                          m_we,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    input  logic                          m_ack,
    input  logic [DATA_W-1:0]             m_rdata,

    output logic                          b_rd_i,
    output logic                          b_rd,
    output logic                          b_wr
);

    localparam int CW    = $clog2(LINE_BEATS);
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            lg, lg_nxt;

    logic            d_any;
    logic            in_burst;
    logic            i_side;
    logic            last_beat;
    logic            beat_ack;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] offs;

    assign d_any     = d_rd | d_wr;
    assign in_burst  = (state != IDLE);
    assign i_side    = (state == I_RD);
    assign last_beat = (cnt == CW'(LINE_BEATS - 1));
    assign beat_ack  = in_burst & m_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lg    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lg    <= lg_nxt;
        end
    end

    // lg records the last granted side; on a tie the other side wins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lg_nxt    = lg;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (i_req && (!d_any || lg)) begin
                    state_nxt = I_RD;
                    lg_nxt    = 1'b0;
                end else if (d_any) begin
                    state_nxt = d_wr ? D_WR : D_RD;
                    lg_nxt    = 1'b1;
                end
            end
            default: begin
                if (m_ack) begin
                    if (last_beat) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // Bases are line-aligned, so adding the beat offset never carries out of the line.
    assign base    = i_side ? i_addr : d_addr;
    assign offs    = ADDR_W'(cnt) * ADDR_W'(BYTES);

    assign m_req   = in_burst;
    assign m_we    = (state == D_WR);
    assign m_addr  = base + offs;
    assign m_wdata = d_wdata;
    assign d_beat  = cnt;

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign i_vld   = beat_ack & i_side;
    assign d_vld   = beat_ack & ~i_side;
    assign i_done  = i_vld & last_beat;
    assign d_done  = d_vld & last_beat;

    // Stall flags cover the wait-for-grant phase and are forced low during reset.
    assign b_rd_i  = ~rst & i_req & ~i_done;
    assign b_rd    = ~rst & d_rd  & ~d_done;
    assign b_wr    = ~rst & d_wr  & ~d_done;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a burst-level reference model.
module tb_mem_arb;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LB = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_vld, i_done;
    logic          d_rd = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [CW-1:0] d_beat;
    logic [DW-1:0] d_rdata;
    logic          d_vld, d_done;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          b_rd_i, b_rd, b_wr;

    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_vld(i_vld), .i_done(i_done),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_beat(d_beat),
        .d_rdata(d_rdata), .d_vld(d_vld), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .b_rd_i(b_rd_i), .b_rd(b_rd), .b_wr(b_wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;
    bit hold_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data read, 3 data write),
    // how many beats of the current line have been delivered, and who was served last.
    int e_side = 0;
    int e_done_beats = 0;
    bit e_last_was_d = 1;
    bit fin_i = 0, fin_d = 0;

    always @(posedge clk or posedge rst) begin
        fin_i = 0;
        fin_d = 0;
        if (rst) begin
            e_side = 0;
            e_done_beats = 0;
            e_last_was_d = 1;
        end else if (e_side == 0) begin
            e_done_beats = 0;
            if (i_req && (d_rd || d_wr))
                e_side = e_last_was_d ? 1 : (d_wr ? 3 : 2);
            else if (i_req)
                e_side = 1;
            else if (d_rd || d_wr)
                e_side = d_wr ? 3 : 2;
            if (e_side != 0) e_last_was_d = (e_side != 1);
        end else if (m_ack) begin
            e_done_beats++;
            if (e_done_beats == LB) begin
                fin_i = (e_side == 1);
                fin_d = (e_side != 1);
                e_side = 0;
                e_done_beats = 0;
            end
        end
    end

    logic [AW-1:0] e_base;
    bit e_ack, e_last;

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            e_ack  = (e_side != 0) && m_ack;
            e_last = e_ack && (e_done_beats == LB - 1);
            e_base = (e_side == 1) ? i_addr : d_addr;
            chk("m_req", m_req, e_side != 0);
            chk("m_we", m_we, e_side == 3);
            chk("d_beat", d_beat, e_done_beats);
            if (e_side != 0) begin
                chk("m_addr", m_addr, e_base + 64'(e_done_beats) * (DW / 8));
                chk("m_wdata", m_wdata, d_wdata);
            end
            chk("i_vld", i_vld, e_ack && e_side == 1);
            chk("i_done", i_done, e_last && e_side == 1);
            chk("d_vld", d_vld, e_ack && e_side >= 2);
            chk("d_done", d_done, e_last && e_side >= 2);
            if (e_ack) chk("rdata", (e_side == 1) ? i_rdata : d_rdata, m_rdata);
            chk("b_rd_i", b_rd_i, i_req && !(e_last && e_side == 1));
            chk("b_rd", b_rd, d_rd && !(e_last && e_side >= 2));
            chk("b_wr", b_wr, d_wr && !(e_last && e_side >= 2));
        end
    end

    function automatic logic [AW-1:0] rand_line();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        return a & ~64'h3F;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_req = 0; d_rd = 0; d_wr = 0; m_ack = 0; hold_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;
    endtask

    // Advance one cycle; requesters release after their done unless holding.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_mode) begin
            if (fin_i) i_req = 0;
            if (fin_d) begin d_rd = 0; d_wr = 0; end
        end
    endtask

    // Wait for the next rising edge of m_req and report which side owns beat 0.
    task automatic next_grant(output int side);
        logic prev;
        side = 0;
        prev = m_req;
        for (int k = 0; k < 60; k++) begin
            tick();
            @(negedge clk);
            if (m_req && !prev) begin
                side = i_vld ? 1 : (d_vld ? (m_we ? 3 : 2) : 4);
                break;
            end
            prev = m_req;
        end
        chk("grant_seen", side != 0, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && (i_req || d_rd || d_wr); k++) tick();
    endtask

    int s;

    initial begin
        m_rdata = {$urandom, $urandom};
        do_reset();
        chk("rst_m_req", m_req, 0);
        chk("rst_beat", d_beat, 0);

        // Single fetch burst, always acked.
        m_ack = 1;
        @(posedge clk); #1 i_req = 1; i_addr = 64'h1000;
        @(negedge clk);
        chk("t1_req_lat", m_req, 0);
        chk("t1_busy_wait", b_rd_i, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            m_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("t1_m_req", m_req, 1);
            chk("t1_addr", m_addr, 64'h1000 + 64'(k) * 8);
            chk("t1_vld", i_vld, 1);
            chk("t1_done", i_done, k == 7);
            chk("t1_busy", b_rd_i, k != 7);
        end
        tick();
        @(negedge clk);
        chk("t1_end_req", m_req, 0);
        chk("t1_end_busy", b_rd_i, 0);

        // Data write burst with ack every other cycle.
        m_ack = 0;
        @(posedge clk); #1 d_wr = 1; d_addr = 64'h2000;
        tick();
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            m_ack = (c % 2 == 1);
            d_wdata = {$urandom, $urandom};
            @(negedge clk);
            chk("t2_m_req", m_req, 1);
            chk("t2_we", m_we, 1);
            chk("t2_beat", d_beat, c / 2);
            chk("t2_addr", m_addr, 64'h2000 + 64'(c / 2) * 8);
            chk("t2_vld", d_vld, c % 2 == 1);
            chk("t2_done", d_done, c == 15);
        end
        tick();
        m_ack = 0;
        @(negedge clk);
        chk("t2_len", m_req, 0);

        // Simultaneous requests after reset: I first, then D; then alternation.
        do_reset();
        m_ack = 1;
        @(posedge clk); #1 i_req = 1; i_addr = 64'h1000; d_rd = 1; d_addr = 64'h2000;
        next_grant(s); chk("t3_first", s, 1);
        next_grant(s); chk("t3_second", s, 2);
        wait_idle();
        i_req = 1;
        next_grant(s); chk("t3_solo", s, 1);
        wait_idle();
        i_req = 1; d_rd = 1;
        next_grant(s); chk("t3_alt_first", s, 2);
        next_grant(s); chk("t3_alt_second", s, 1);
        wait_idle();

        // Continuous contention alternates.
        do_reset();
        m_ack = 1;
        hold_mode = 1;
        @(posedge clk); #1 i_req = 1; d_rd = 1;
        for (int g = 0; g < 6; g++) begin
            next_grant(s);
            chk("t4_order", s, (g % 2 == 0) ? 1 : 2);
        end
        hold_mode = 0;

        // Reset during beat 3 of a data read.
        do_reset();
        m_ack = 1;
        @(posedge clk); #1 d_rd = 1; d_addr = 64'h2000;
        next_grant(s); chk("t5_grant", s, 2);
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        tick();
        chk("t5_beat3", d_beat, 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_req_drop", m_req, 0);
        chk("t5_vld_drop", d_vld, 0);
        chk("t5_no_done", d_done, 0);
        chk("t5_busy_rst", b_rd, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        next_grant(s);
        chk("t5_regrant", s, 2);
        chk("t5_addr", m_addr, 64'h2000);
        chk("t5_beat0", d_beat, 0);
        wait_idle();

        // Randomized traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            m_ack = ($urandom_range(99) < 70);
            m_rdata = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
            if (!i_req && $urandom_range(3) == 0) begin
                i_req = 1;
                i_addr = rand_line();
            end
            if (!d_rd && !d_wr && $urandom_range(3) == 0) begin
                if ($urandom_range(1) == 1) d_wr = 1;
                else d_rd = 1;
                d_addr = rand_line();
            end
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
